// File: rtl/multiword_comparator.sv
// Sequential multi-word magnitude comparator.
// Operands A and B are streamed one WIDTH-bit word pair per cycle, most
// significant word first. Only the first word (MSW) is compared signed when
// is_signed is set; the remaining words are always unsigned. The first
// difference found decides the result. The equal/greater/less/len_err flags
// are registered and held until the next out_valid pulse.
module multiword_comparator #(
  parameter int WIDTH     = 8,
  parameter int MAX_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             is_equal,
  output logic             is_great,
  output logic             is_less,
  output logic             len_err
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAXW_C = CW'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_EQ = 2'd0,
    DEC_GT = 2'd1,
    DEC_LT = 2'd2
  } dec_t;

  // Compare one word pair. sgn selects two's-complement interpretation.
  function automatic dec_t cmp_word(input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b,
                                    input logic             sgn);
    dec_t d;
    d = DEC_EQ;
    if (sgn) begin
      if ($signed(a) > $signed(b))      d = DEC_GT;
      else if ($signed(a) < $signed(b)) d = DEC_LT;
    end else begin
      if (a > b)      d = DEC_GT;
      else if (a < b) d = DEC_LT;
    end
    return d;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  dec_t            r_dec;
  dec_t            w_dec_nxt;
  dec_t            w_word_dec;
  logic            w_fire;
  logic            w_ovf;

  // Sequencer state, word count and running decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_dec   <= DEC_EQ;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_dec   <= w_dec_nxt;
    end
  end

  // Next-state logic: decision update, length tracking, result strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_dec_nxt   = r_dec;
    w_fire      = 1'b0;
    w_ovf       = 1'b0;
    // The sign only matters on the first word; lower words are magnitudes.
    w_word_dec  = cmp_word(A, B, (r_state == S_IDLE) ? is_signed : 1'b0);

    if (in_valid) begin
      case (r_state)
        S_IDLE: begin
          w_dec_nxt   = w_word_dec;
          w_count_nxt = CW'(1);
          if (in_last) begin
            w_fire = 1'b1;
          end else if (MAX_WORDS == 1) begin
            w_fire      = 1'b1;
            w_ovf       = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end
        S_ACCUM: begin
          // Once a higher word differs, lower words cannot change the outcome.
          if (r_dec == DEC_EQ) w_dec_nxt = w_word_dec;
          w_count_nxt = r_count + CW'(1);
          if (in_last) begin
            w_fire      = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_count_nxt == MAXW_C) begin
            w_fire      = 1'b1;
            w_ovf       = 1'b1;
            w_state_nxt = S_DROP;
          end
        end
        S_DROP: begin
          // Tail of an over-long operand: swallow words until the last one.
          if (in_last) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Registered result flags, updated only when a result is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      is_equal  <= 1'b0;
      is_great  <= 1'b0;
      is_less   <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      out_valid <= w_fire;
      if (w_fire) begin
        is_equal <= (w_dec_nxt == DEC_EQ);
        is_great <= (w_dec_nxt == DEC_GT);
        is_less  <= (w_dec_nxt == DEC_LT);
        len_err  <= w_ovf;
      end
    end
  end

endmodule
